// File: rtl/jtsbaskt_objbuf.sv
// Double-banked object line buffer: the draw side fills one 256-pixel bank while
// the display side reads (and erases) the other; banks swap on each LHBL fall.
module jtsbaskt_objbuf #(
    parameter logic [7:0] HOFFSET = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic [8:0] hdump,
    input  logic       flip,
    input  logic [7:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_en,
    output logic       line_start,
    output logic       busy,
    output logic [3:0] obj_pxl
);

    typedef enum logic { CLEAR, RUN } state_t;

    state_t     state;
    logic [7:0] clr_cnt;
    logic       disp_bank;   // draw bank is always the other one
    logic       lhbl_l;
    logic       rd_valid;
    logic       rd_bank;
    logic [7:0] rd_addr;

    logic [3:0] mem0 [256];
    logic [3:0] mem1 [256];

    logic [7:0] rd_sum;
    logic [7:0] rd_next;
    logic [3:0] rd_data;
    logic       lhbl_fall;
    logic       sweep_we;
    logic       clr_we;
    logic       draw_we;
    logic       unused_hdump;

    // The buffer is exactly one 256-pixel line, so the ninth counter bit plays no part.
    assign unused_hdump = hdump[8];

    assign rd_sum    = hdump[7:0] + HOFFSET;
    assign rd_next   = flip ? ~rd_sum : rd_sum;
    assign rd_data   = rd_bank ? mem1[rd_addr] : mem0[rd_addr];
    assign lhbl_fall = lhbl_l & ~LHBL;

    assign sweep_we = !rst && state == CLEAR;
    assign clr_we   = !rst && state == RUN && pxl_cen && rd_valid;
    assign draw_we  = !rst && state == RUN && wr_en && wr_data != 4'd0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clr_cnt    <= 8'd0;
            busy       <= 1'b1;
            disp_bank  <= 1'b0;
            lhbl_l     <= 1'b1;
            line_start <= 1'b0;
            obj_pxl    <= 4'd0;
            rd_valid   <= 1'b0;
            rd_bank    <= 1'b0;
            rd_addr    <= 8'd0;
        end else begin
            lhbl_l     <= LHBL;
            line_start <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_cnt  <= clr_cnt + 8'd1;
                    obj_pxl  <= 4'd0;
                    rd_valid <= 1'b0;
                    if (clr_cnt == 8'hff) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (lhbl_fall) begin
                        disp_bank  <= ~disp_bank;
                        line_start <= 1'b1;
                    end
                    if (pxl_cen) begin
                        obj_pxl  <= rd_valid ? rd_data : 4'd0;
                        rd_valid <= LHBL;
                        // The bank is captured with the address so a read straddling
                        // a swap still finishes on the bank it started on.
                        if (LHBL) begin
                            rd_addr <= rd_next;
                            rd_bank <= disp_bank;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // NOTE: the storage arrays have no reset branch; the CLEAR sweep zeroes them,
    // which keeps them mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem0[clr_cnt] <= 4'd0;
            mem1[clr_cnt] <= 4'd0;
        end else begin
            if (clr_we) begin
                if (rd_bank) mem1[rd_addr] <= 4'd0;
                else         mem0[rd_addr] <= 4'd0;
            end
            // Placed after the erase so a fresh draw pixel wins a same-address collision.
            if (draw_we) begin
                if (disp_bank) mem0[wr_addr] <= wr_data;
                else           mem1[wr_addr] <= wr_data;
            end
        end
    end

endmodule
